conj_burst_arbiter: RTL and testbench
=====================================

// Module: conj_burst_arbiter
// PURPOSE
//  Shares one Conjugate unit between two antenna sample streams (MIMO RX chains 0/1).
//  Grants whole OFDM symbols (N_SC samples) to one requester at a time, round-robin.
//  Feeds granted samples to the Conjugate instance and re-tags its output with stream id and
//  symbol framing. Sits between the FFT output buffers and the channel-estimation multiplier.
// PARAMETERS
//  DW    `FIXED_POINT_WIDTH  signed width of real/imag samples
//  N_SC  64                  samples per burst (subcarriers per OFDM symbol), >=2
//  CNT_W $clog2(N_SC)        width of the in-burst sample counter, derived
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  req0_real  in   DW  stream 0 real sample, signed
//  req0_imag  in   DW  stream 0 imag sample, signed
//  req0_valid in   1   stream 0 sample present
//  req0_ready out  1   stream 0 sample accepted this cycle when valid&ready
//  req1_real  in   DW  stream 1 real sample, signed
//  req1_imag  in   DW  stream 1 imag sample, signed
//  req1_valid in   1   stream 1 sample present
//  req1_ready out  1   stream 1 ready
//  out_real   out  DW  conjugated real part, signed
//  out_imag   out  DW  conjugated imag part, signed
//  out_valid  out  1   out_* qualifier, no backpressure
//  out_id     out  1   stream that produced this output
//  out_sof    out  1   first sample of a burst
//  out_eof    out  1   last sample of a burst
//  busy       out  1   high in BURST state
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, last_grant=1 (stream 0 wins the first tie), all outputs 0.
//  FSM IDLE: no readies. If any reqX_valid: owner = round-robin pick (prefer !last_grant
//   when both valid, else the single valid one), cnt<=0, go BURST. Arbitration costs 1 cycle.
//  FSM BURST: reqX_ready = (owner==X), combinational from state/owner only (never from valid).
//   Accept = req_valid[owner] & ready. Each accept drives u_conj valid/real/imag same cycle
//   and cnt<=cnt+1. Valid gaps allowed; cnt holds; no timeout.
//   Accept with cnt==N_SC-1: last_grant<=owner, cnt<=0, go IDLE.
//  Non-owner valid during BURST is ignored; its sample is held upstream (ready=0).
//  Conjugate: 1-cycle latency, outputs 0 when its valid is low. Sideband (valid, id, sof=cnt==0,
//   eof=cnt==N_SC-1) delayed 1 cycle alongside it, then all out_* registered once more.
//  Latency: accept at cycle T -> out_valid at T+2. out_real/out_imag = 0 when out_valid=0.
//  Arithmetic: out_imag = -imag in DW bits, two's complement wrap; -(2^(DW-1)) maps to itself
//   (no saturation). out_real = real unchanged.
//  Throughput: 1 sample/cycle inside a burst; 1 idle cycle between bursts.
//  Reset mid-burst: FSM->IDLE, cnt=0, pipeline valids cleared; partial burst dropped, never
//   emits eof; the next burst starts with sof. Conjugate data registers are not reset; masked
//   by the cleared valid pipeline.
//  Both streams valid continuously: grants alternate 0,1,0,1... by whole bursts.
// STRUCTURE
//  header.vh: FIXED_POINT_WIDTH (existing), N_SC_DEFAULT, FSM state encodings
//   ST_IDLE/ST_BURST.
//  Sub-module rr_burst_arbiter (FSM, cnt, owner, last_grant, readies).
//  Top instantiates it plus Conjugate u_conj and the 2-stage sideband/output pipeline.
// TESTING (sim with N_SC=4, DW=16)
//  1 Stream 0 only, valid 4 cycles, samples (1,2),(3,-4),(5,6),(7,8) -> out (1,-2),(3,4),
//    (5,-6),(7,-8), id=0, sof on first, eof on 4th, each out 2 cycles after accept.
//  2 Both valid continuously -> bursts id 0,1,0,1; 1 bubble between bursts; ready never high
//    on both streams in the same cycle.
//  3 Stream 1 drops valid after 2 samples for 3 cycles -> cnt holds; eof only on 4th
//    accepted sample; no out_valid in the gap.
//  4 imag=-32768 -> out_imag=-32768; imag=32767 -> -32767.
//  5 rst asserted after 2 accepts -> out_valid=0 from the next cycle, no eof; after release
//    stream 0 burst restarts with sof and 4 samples.
//  6 Stream 1 alone after a stream-1 burst -> granted again (round-robin does not starve
//    a lone requester).

Source files
------------

// File: rtl/conj_burst_arbiter_pkg.sv
// Shared types for the two-stream conjugate burst arbiter.
// Fixed-point width, default burst length, FSM states and sideband bundle.
package conj_burst_arbiter_pkg;

  localparam int FIXED_POINT_WIDTH = 16;
  localparam int N_SC_DEFAULT      = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic id;
    logic sof;
    logic eof;
  } sb_t;

endpackage

// File: rtl/conj_burst_arbiter_if.sv
// Sample streams in, conjugated tagged stream out.
// master = sample sources / sink, slave = the arbiter.
interface conj_burst_arbiter_if #(
  parameter int DW = conj_burst_arbiter_pkg::FIXED_POINT_WIDTH
);

  logic signed [DW-1:0] req0_real;
  logic signed [DW-1:0] req0_imag;
  logic                 req0_valid;
  logic                 req0_ready;
  logic signed [DW-1:0] req1_real;
  logic signed [DW-1:0] req1_imag;
  logic                 req1_valid;
  logic                 req1_ready;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic                 out_valid;
  logic                 out_id;
  logic                 out_sof;
  logic                 out_eof;
  logic                 busy;

  modport master (
    output req0_real, req0_imag, req0_valid,
    output req1_real, req1_imag, req1_valid,
    input  req0_ready, req1_ready,
    input  out_real, out_imag, out_valid,
    input  out_id, out_sof, out_eof, busy
  );

  modport slave (
    input  req0_real, req0_imag, req0_valid,
    input  req1_real, req1_imag, req1_valid,
    output req0_ready, req1_ready,
    output out_real, out_imag, out_valid,
    output out_id, out_sof, out_eof, busy
  );

endinterface

// File: rtl/conj_burst_arbiter_conj.sv
// Complex conjugate, one cycle latency, zero output when not valid.
// Data registers are unreset; the reset valid flag masks them.
module conjugate #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_imag
);

  logic                 v_q;
  logic signed [DW-1:0] re_q;
  logic signed [DW-1:0] im_q;

  always_ff @(posedge clk) begin
    if (rst) v_q <= 1'b0;
    else     v_q <= in_valid;
  end

  // Negation wraps: the most negative value maps to itself
  always_ff @(posedge clk) begin
    if (in_valid) begin
      re_q <= in_real;
      im_q <= -in_imag;
    end
  end

  assign out_real = v_q ? re_q : '0;
  assign out_imag = v_q ? im_q : '0;

endmodule

// File: rtl/conj_burst_arbiter_rr.sv
// Round-robin whole-burst arbiter for two requesters.
// Owns the FSM, in-burst counter, owner and last grant.
module rr_burst_arbiter
  import conj_burst_arbiter_pkg::*;
#(
  parameter int N_SC  = N_SC_DEFAULT,
  parameter int CNT_W = $clog2(N_SC)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] ready,
  output logic       accept,
  output logic       owner,
  output logic       sof,
  output logic       eof,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             owner_nxt;
  logic             last;
  logic             last_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    last_nxt  = last;
    unique case (state)
      ST_IDLE: begin
        if (|valid) begin
          owner_nxt = (&valid) ? ~last : valid[1];
          cnt_nxt   = '0;
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (accept) begin
          if (eof) begin
            cnt_nxt   = '0;
            last_nxt  = owner;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Readies depend on state and owner only, never on valid
  always_comb begin
    ready  = '0;
    busy   = 1'b0;
    unique case (1'b1)
      (state == ST_BURST): begin
        busy         = 1'b1;
        ready[owner] = 1'b1;
      end
      default: ;
    endcase
    accept = busy & valid[owner];
    sof    = (cnt == '0);
    eof    = (cnt == CNT_LAST);
  end

endmodule

// File: rtl/conj_burst_arbiter.sv
// Shares one conjugate unit between two sample streams by whole bursts.
// Output is re-tagged with stream id and burst framing, two cycles after accept.
module conj_burst_arbiter
  import conj_burst_arbiter_pkg::*;
#(
  parameter int DW   = FIXED_POINT_WIDTH,
  parameter int N_SC = N_SC_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  conj_burst_arbiter_if.slave bus
);

  logic [1:0]           ready;
  logic                 accept;
  logic                 owner;
  logic                 sof;
  logic                 eof;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic signed [DW-1:0] c_real;
  logic signed [DW-1:0] c_imag;
  sb_t                  s1;

  rr_burst_arbiter #(
    .N_SC (N_SC)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .ready  (ready),
    .accept (accept),
    .owner  (owner),
    .sof    (sof),
    .eof    (eof),
    .busy   (bus.busy)
  );

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];

  assign in_real = owner ? bus.req1_real : bus.req0_real;
  assign in_imag = owner ? bus.req1_imag : bus.req0_imag;

  conjugate #(
    .DW (DW)
  ) u_conj (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .out_real (c_real),
    .out_imag (c_imag)
  );

  // Sideband travels beside the conjugate's internal register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1 <= '{valid: accept,
              id:    accept & owner,
              sof:   accept & sof,
              eof:   accept & eof};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_id    <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
      bus.out_real  <= '0;
      bus.out_imag  <= '0;
    end else begin
      bus.out_valid <= s1.valid;
      bus.out_id    <= s1.id;
      bus.out_sof   <= s1.sof;
      bus.out_eof   <= s1.eof;
      bus.out_real  <= c_real;
      bus.out_imag  <= c_imag;
    end
  end

endmodule

// File: tb/tb_conj_burst_arbiter.sv
// Randomized and directed bench for conj_burst_arbiter (N_SC=4, DW=16).
// Reference model: burst-level grant rules plus a two-deep output delay queue.
module tb_conj_burst_arbiter;
  import conj_burst_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int N  = 4;

  typedef struct packed {
    logic          v;
    logic          id;
    logic          sof;
    logic          eof;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } ob_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conj_burst_arbiter_if #(.DW(DW)) bus ();

  conj_burst_arbiter #(
    .DW   (DW),
    .N_SC (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ob_t           pipe[$];
  bit            m_busy = 1'b0;
  bit            m_own  = 1'b0;
  bit            m_last = 1'b1;
  int            m_cnt  = 0;
  logic [DW-1:0] s_re[2];
  logic [DW-1:0] s_im[2];
  int            n_chk  = 0;
  int            n_fail = 0;

  // One clock: drive, sample, advance the model.
  // st/est = {busy, req1_ready, req0_ready}
  task automatic cyc(input bit v0, input bit v1, input bit r,
                     output ob_t o, output ob_t e,
                     output logic [2:0] st, output logic [2:0] est,
                     output bit acc);
    ob_t n;
    n   = '0;
    acc = 1'b0;
    @(negedge clk);
    rst            = r;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_real  = s_re[0];
    bus.req0_imag  = s_im[0];
    bus.req1_real  = s_re[1];
    bus.req1_imag  = s_im[1];
    #1;
    o.v  = bus.out_valid;
    o.id = bus.out_id;
    o.sof = bus.out_sof;
    o.eof = bus.out_eof;
    o.re = bus.out_real;
    o.im = bus.out_imag;
    e    = pipe[0];
    st   = {bus.busy, bus.req1_ready, bus.req0_ready};
    est  = m_busy ? {1'b1, m_own, !m_own} : 3'b000;
    if (r) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_last = 1'b1;
      pipe.delete();
      pipe.push_back(n);
      pipe.push_back(n);
    end else begin
      if (!m_busy) begin
        if (v0 || v1) begin
          m_own  = (v0 && v1) ? !m_last : v1;
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end else if (m_own ? v1 : v0) begin
        acc   = 1'b1;
        n.v   = 1'b1;
        n.id  = m_own;
        n.sof = (m_cnt == 0);
        n.eof = (m_cnt == N - 1);
        n.re  = s_re[m_own];
        n.im  = -s_im[m_own];
        m_cnt++;
        if (m_cnt == N) begin
          m_busy = 1'b0;
          m_cnt  = 0;
          m_last = m_own;
        end
        s_re[m_own] = DW'($urandom);
        s_im[m_own] = DW'($urandom);
      end
      void'(pipe.pop_front());
      pipe.push_back(n);
    end
  endtask

  task automatic drain();
    ob_t o, e;
    logic [2:0] s, es;
    bit a;
    int i;
    for (i = 0; i < 20; i++) begin
      if (!m_busy && !pipe[0].v && !pipe[1].v) break;
      cyc(m_busy && !m_own, m_busy && m_own, 1'b0, o, e, s, es, a);
    end
    if (i == 20) begin
      n_fail++;
      $display("FAIL drain_timeout: busy=%0d after %0d cycles", m_busy, i);
    end
  endtask

  task automatic test_reset();
    ob_t o, e;
    logic [2:0] s, es;
    bit a;
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, o, e, s, es, a);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, o, e, s, es, a);
      n_chk++;
      if (o !== ob_t'(0)) begin
        n_fail++;
        $display("FAIL reset_out: got %h want 0", o);
      end
      n_chk++;
      if (s !== es) begin
        n_fail++;
        $display("FAIL reset_ctl: got %b want %b", s, es);
      end
    end
  endtask

  task automatic test_single();
    logic signed [DW-1:0] tre[4] = '{16'sd1, 16'sd3, 16'sd5, 16'sd7};
    logic signed [DW-1:0] tim[4] = '{16'sd2, -16'sd4, 16'sd6, 16'sd8};
    logic signed [DW-1:0] xim[4] = '{-16'sd2, 16'sd4, -16'sd6, -16'sd8};
    ob_t o, e;
    logic [2:0] s, es;
    bit a;
    int k = 0, j = 0, t_acc = -1, t_out = -1;
    for (int i = 0; i < 12; i++) begin
      if (k < 4) begin
        s_re[0] = tre[k];
        s_im[0] = tim[k];
      end
      cyc(k < 4, 1'b0, 1'b0, o, e, s, es, a);
      if (a && t_acc < 0) t_acc = i;
      if (a) k++;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_out: got %h want %h", o, e);
      end
      n_chk++;
      if (s !== es) begin
        n_fail++;
        $display("FAIL single_ctl: got %b want %b", s, es);
      end
      if (o.v === 1'b1 && j < 4) begin
        if (t_out < 0) t_out = i;
        n_chk++;
        if ({o.re, o.im, o.id, o.sof, o.eof} !==
            {tre[j], xim[j], 1'b0, j == 0, j == 3}) begin
          n_fail++;
          $display("FAIL single_val%0d: got %h/%h id%b s%b e%b want %h/%h",
                   j, o.re, o.im, o.id, o.sof, o.eof, tre[j], xim[j]);
        end
        j++;
      end
    end
    n_chk++;
    if (j != 4 || t_out - t_acc != 2) begin
      n_fail++;
      $display("FAIL single_lat: outs %0d latency %0d want 4 and 2",
               j, t_out - t_acc);
    end
    drain();
  endtask

  task automatic test_both();
    ob_t o, e;
    logic [2:0] s, es;
    bit a;
    bit prev = 1'b0;
    int nb = 0;
    for (int i = 0; i < 27; i++) begin
      cyc(i < 25, i < 25, 1'b0, o, e, s, es, a);
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL both_out: got %h want %h", o, e);
      end
      n_chk++;
      if (s !== es || s[1:0] === 2'b11) begin
        n_fail++;
        $display("FAIL both_ctl: got %b want %b", s, es);
      end
      if (o.v === 1'b1 && o.sof === 1'b1) begin
        n_chk++;
        if (nb > 0 && o.id === prev) begin
          n_fail++;
          $display("FAIL both_alt: got id %b want %b", o.id, !prev);
        end
        prev = o.id;
        nb++;
      end
    end
    n_chk++;
    if (nb != 5) begin
      n_fail++;
      $display("FAIL both_count: got %0d bursts want 5", nb);
    end
    drain();
  endtask

  task automatic test_gap();
    ob_t o, e;
    logic [2:0] s, es;
    bit a;
    bit v;
    int k = 0, g = 0, j = 0;
    for (int i = 0; i < 16; i++) begin
      v = (k < 4) && !(k == 2 && g < 3);
      if (k == 2 && g < 3) g++;
      cyc(1'b0, v, 1'b0, o, e, s, es, a);
      if (a) k++;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL gap_out: got %h want %h", o, e);
      end
      n_chk++;
      if (s !== es) begin
        n_fail++;
        $display("FAIL gap_ctl: got %b want %b", s, es);
      end
      if (o.v === 1'b1) begin
        n_chk++;
        if (o.eof !== (j == 3) || o.id !== 1'b1) begin
          n_fail++;
          $display("FAIL gap_eof: sample %0d eof %b id %b", j, o.eof, o.id);
        end
        j++;
      end
    end
    n_chk++;
    if (j != 4) begin
      n_fail++;
      $display("FAIL gap_count: got %0d want 4", j);
    end
    drain();
  endtask

  task automatic test_wrap();
    logic signed [DW-1:0] tim[4] = '{-16'sd32768, 16'sd32767, 16'sd0, 16'sd1};
    logic signed [DW-1:0] xim[4] = '{-16'sd32768, -16'sd32767, 16'sd0, -16'sd1};
    ob_t o, e;
    logic [2:0] s, es;
    bit a;
    int k = 0, j = 0;
    for (int i = 0; i < 10; i++) begin
      if (k < 4) s_im[0] = tim[k];
      cyc(k < 4, 1'b0, 1'b0, o, e, s, es, a);
      if (a) k++;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap_out: got %h want %h", o, e);
      end
      if (o.v === 1'b1 && j < 4) begin
        n_chk++;
        if (o.im !== xim[j]) begin
          n_fail++;
          $display("FAIL wrap_imag%0d: got %h want %h", j, o.im, xim[j]);
        end
        j++;
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    ob_t o, e;
    logic [2:0] s, es;
    bit a;
    int k = 0, j = 0, i;
    for (i = 0; i < 8 && k < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, o, e, s, es, a);
      if (a) k++;
    end
    n_chk++;
    if (k != 2) begin
      n_fail++;
      $display("FAIL rmid_start: got %0d accepts want 2", k);
    end
    cyc(1'b0, 1'b0, 1'b1, o, e, s, es, a);
    for (i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, o, e, s, es, a);
      n_chk++;
      if (o.v !== 1'b0 || o.eof !== 1'b0 || o !== e) begin
        n_fail++;
        $display("FAIL rmid_flush: got %h want %h", o, e);
      end
    end
    k = 0;
    for (i = 0; i < 10; i++) begin
      cyc(k < 4, 1'b0, 1'b0, o, e, s, es, a);
      if (a) k++;
      n_chk++;
      if (o !== e || s !== es) begin
        n_fail++;
        $display("FAIL rmid_out: got %h/%b want %h/%b", o, s, e, es);
      end
      if (o.v === 1'b1) begin
        n_chk++;
        if (o.sof !== (j == 0) || o.eof !== (j == 3) || o.id !== 1'b0) begin
          n_fail++;
          $display("FAIL rmid_frame%0d: sof %b eof %b id %b",
                   j, o.sof, o.eof, o.id);
        end
        j++;
      end
    end
    n_chk++;
    if (j != 4) begin
      n_fail++;
      $display("FAIL rmid_count: got %0d want 4", j);
    end
    drain();
  endtask

  task automatic test_lone();
    ob_t o, e;
    logic [2:0] s, es;
    bit a;
    int nb = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, i < 10, 1'b0, o, e, s, es, a);
      n_chk++;
      if (o !== e || s !== es) begin
        n_fail++;
        $display("FAIL lone_out: got %h/%b want %h/%b", o, s, e, es);
      end
      if (o.v === 1'b1 && o.sof === 1'b1 && o.id === 1'b1) nb++;
    end
    n_chk++;
    if (nb != 2) begin
      n_fail++;
      $display("FAIL lone_count: got %0d stream-1 bursts want 2", nb);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_re[i] = DW'($urandom);
      s_im[i] = DW'($urandom);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_real  = '0;
    bus.req0_imag  = '0;
    bus.req1_real  = '0;
    bus.req1_imag  = '0;
    pipe.push_back('0);
    pipe.push_back('0);
    test_reset();
    test_single();
    test_both();
    test_gap();
    test_wrap();
    test_reset_mid();
    test_lone();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
